// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control FSM and its opcode decoder.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EX_R, ST_EX_ADDI, ST_MEM_ADDR,
    ST_LW_WB, ST_SW_WR, ST_BR_CMP, ST_BR_TGT, ST_JUMP, ST_EXC
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_ILL
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ULA_PASS = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;
  localparam logic [2:0] ULA_CMP  = 3'b111;

  localparam logic [1:0] ULAB_B       = 2'b00;
  localparam logic [1:0] ULAB_4       = 2'b01;
  localparam logic [1:0] ULAB_SEXT    = 2'b10;
  localparam logic [1:0] ULAB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ULA  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  localparam logic [1:0] PCSRC_EXC  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_OVF     = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/flag bundle between the multicycle datapath (master) and its controller (slave).
interface multicycle_ctrl_if;
  logic       Of, Ng, Zr, Eq, Gt, Lt;
  logic [5:0] OPCODE, FUNCT;
  logic       PCWrite, MemWrite, IRWrite, RegWrite, ABWrite;
  logic       IorD, MemToReg, RegDst_sig, M_ULAA;
  logic [1:0] M_ULAB;
  logic [2:0] ULA_c;
  logic [1:0] PCSrc;
  logic       exc;
  logic [1:0] exc_cause;

  modport master (
    output Of, Ng, Zr, Eq, Gt, Lt, OPCODE, FUNCT,
    input  PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, IorD, MemToReg,
           RegDst_sig, M_ULAA, M_ULAB, ULA_c, PCSrc, exc, exc_cause
  );

  modport slave (
    input  Of, Ng, Zr, Eq, Gt, Lt, OPCODE, FUNCT,
    output PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, IorD, MemToReg,
           RegDst_sig, M_ULAA, M_ULAB, ULA_c, PCSrc, exc, exc_cause
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational OPCODE/FUNCT classifier; also yields the ULA_c used by R-type execute.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output logic [2:0]   r_ulac,
  output logic         illegal
);

  always_comb begin
    cls    = CLS_ILL;
    r_ulac = ULA_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin cls = CLS_R; r_ulac = ULA_ADD; end
          FN_SUB: begin cls = CLS_R; r_ulac = ULA_SUB; end
          FN_AND: begin cls = CLS_R; r_ulac = ULA_AND; end
          default: cls = CLS_ILL;
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      default: cls = CLS_ILL;
    endcase
    illegal = (cls == CLS_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: one micro-step per cycle, Moore-decoded outputs.
// Optional CTRL_OVF_TRAP_EN: overflow on add/sub/addi suppresses RegWrite and traps (cause 10).
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT       = 1,
  parameter logic [1:0]  EXC_VECTOR_SEL = PCSRC_EXC
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.slave bus
);
  // state     | meaning
  // RST       | idle after reset       FETCH    | read IR, PC <= PC+4
  // DECODE    | latch A/B, dispatch    EX_R     | R-type ALU + writeback
  // EX_ADDI   | addi + writeback       MEM_ADDR | address, lw read wait
  // LW_WB     | load writeback         SW_WR    | store strobe
  // BR_CMP    | compare A/B            BR_TGT   | PC <= PC+4+(off<<2)
  // JUMP      | PC <= jump target      EXC      | PC <= exception vector

  // The lw read starts once ULA_out holds the address, then needs W+1 cycles like fetch.
  localparam logic [3:0] FETCH_TC = 4'(MEM_WAIT);
  localparam logic [3:0] LW_TC    = 4'(MEM_WAIT + 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   exc_cause_q, exc_cause_d;
  instr_class_e cls;
  logic [2:0]   r_ulac;
  logic         illegal;
  logic         ovf_trap;
  logic         unused_flags;

  ctrl_decode u_decode (
    .opcode  (bus.OPCODE),
    .funct   (bus.FUNCT),
    .cls     (cls),
    .r_ulac  (r_ulac),
    .illegal (illegal)
  );

`ifdef CTRL_OVF_TRAP_EN
  assign ovf_trap = bus.Of && ((state_q == ST_EX_R && r_ulac != ULA_AND) ||
                               state_q == ST_EX_ADDI);
  assign unused_flags = ^{bus.Ng, bus.Zr, bus.Gt, bus.Lt};
`else
  assign ovf_trap = 1'b0;
  assign unused_flags = ^{bus.Ng, bus.Zr, bus.Gt, bus.Lt, bus.Of};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      exc_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    exc_cause_d = exc_cause_q;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (cnt_q == FETCH_TC) state_d = ST_DECODE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ST_DECODE: begin
        if (illegal) begin
          state_d     = ST_EXC;
          exc_cause_d = CAUSE_ILLEGAL;
        end else begin
          case (cls)
            CLS_R:            state_d = ST_EX_R;
            CLS_ADDI:         state_d = ST_EX_ADDI;
            CLS_LW, CLS_SW:   state_d = ST_MEM_ADDR;
            CLS_BEQ, CLS_BNE: state_d = ST_BR_CMP;
            CLS_J:            state_d = ST_JUMP;
            default: begin
              state_d     = ST_EXC;
              exc_cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      ST_EX_R, ST_EX_ADDI: begin
        if (ovf_trap) begin
          state_d     = ST_EXC;
          exc_cause_d = CAUSE_OVF;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM_ADDR: begin
        if (cls == CLS_SW)      state_d = ST_SW_WR;
        else if (cnt_q == LW_TC) state_d = ST_LW_WB;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      ST_BR_CMP: begin
        if ((cls == CLS_BEQ && bus.Eq) || (cls == CLS_BNE && !bus.Eq)) state_d = ST_BR_TGT;
        else                                                            state_d = ST_FETCH;
      end
      ST_LW_WB, ST_SW_WR, ST_BR_TGT, ST_JUMP, ST_EXC: state_d = ST_FETCH;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ABWrite    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemToReg   = 1'b0;
    bus.RegDst_sig = 1'b0;
    bus.M_ULAA     = 1'b0;
    bus.M_ULAB     = ULAB_B;
    bus.ULA_c      = ULA_PASS;
    bus.PCSrc      = PCSRC_ULA;
    bus.exc        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.M_ULAB = ULAB_4;
        bus.ULA_c  = ULA_ADD;
        if (cnt_q == FETCH_TC) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
        end
      end
      ST_DECODE: bus.ABWrite = 1'b1;
      ST_EX_R: begin
        bus.M_ULAA     = 1'b1;
        bus.ULA_c      = r_ulac;
        bus.RegDst_sig = 1'b1;
        bus.RegWrite   = !ovf_trap;
      end
      ST_EX_ADDI: begin
        bus.M_ULAA   = 1'b1;
        bus.M_ULAB   = ULAB_SEXT;
        bus.ULA_c    = ULA_ADD;
        bus.RegWrite = !ovf_trap;
      end
      ST_MEM_ADDR, ST_SW_WR: begin
        bus.M_ULAA   = 1'b1;
        bus.M_ULAB   = ULAB_SEXT;
        bus.ULA_c    = ULA_ADD;
        bus.IorD     = 1'b1;
        bus.MemWrite = (state_q == ST_SW_WR);
      end
      ST_LW_WB: begin
        bus.MemToReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      ST_BR_CMP: begin
        bus.M_ULAA = 1'b1;
        bus.ULA_c  = ULA_CMP;
      end
      ST_BR_TGT: begin
        bus.M_ULAB  = ULAB_SEXT_SH;
        bus.ULA_c   = ULA_ADD;
        bus.PCWrite = 1'b1;
      end
      ST_JUMP: begin
        bus.PCSrc   = PCSRC_JUMP;
        bus.PCWrite = 1'b1;
      end
      ST_EXC: begin
        bus.PCSrc   = EXC_VECTOR_SEL;
        bus.PCWrite = 1'b1;
        bus.exc     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.exc_cause = exc_cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected micro-step sequences.
module tb_multicycle_ctrl;

  localparam int W = 2;
`ifdef CTRL_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, memw, irw, regw, abw, iord, m2r, rdst, mulaa;
    logic [1:0] mulab;
    logic [2:0] ulac;
    logic [1:0] pcsrc;
    logic       exc;
    logic [1:0] cause;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl #(.MEM_WAIT(W), .EXC_VECTOR_SEL(2'b11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ctl_t       exp_q[$];
  logic [1:0] model_cause = 2'b00;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic ctl_t sample();
    return {bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ABWrite,
            bus.IorD, bus.MemToReg, bus.RegDst_sig, bus.M_ULAA, bus.M_ULAB,
            bus.ULA_c, bus.PCSrc, bus.exc, bus.exc_cause};
  endfunction

  task automatic push_exc(input logic [1:0] c);
    ctl_t e;
    e = '0;
    e.pcw = 1'b1; e.pcsrc = 2'b11; e.exc = 1'b1; e.cause = c;
    model_cause = c;
    exp_q.push_back(e);
  endtask

  // Expected per-cycle outputs of one instruction, starting at its first fetch cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic of);
    ctl_t s;
    bit   ovf;
    exp_q.delete();
    for (int i = 0; i <= W; i++) begin
      s = '0; s.mulab = 2'b01; s.ulac = 3'b001;
      s.irw = (i == W); s.pcw = (i == W); s.cause = model_cause;
      exp_q.push_back(s);
    end
    s = '0; s.abw = 1'b1; s.cause = model_cause;
    exp_q.push_back(s);
    s = '0; s.cause = model_cause;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      s.mulaa = 1'b1; s.rdst = 1'b1;
      s.ulac = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      ovf = TRAP_EN && of && (fn != 6'h24);
      s.regw = !ovf;
      exp_q.push_back(s);
      if (ovf) push_exc(2'b10);
    end else if (op == 6'h08) begin
      s.mulaa = 1'b1; s.mulab = 2'b10; s.ulac = 3'b001;
      ovf = TRAP_EN && of;
      s.regw = !ovf;
      exp_q.push_back(s);
      if (ovf) push_exc(2'b10);
    end else if (op == 6'h23) begin
      s.mulaa = 1'b1; s.mulab = 2'b10; s.ulac = 3'b001; s.iord = 1'b1;
      repeat (W + 2) exp_q.push_back(s);
      s = '0; s.cause = model_cause; s.m2r = 1'b1; s.regw = 1'b1;
      exp_q.push_back(s);
    end else if (op == 6'h2B) begin
      s.mulaa = 1'b1; s.mulab = 2'b10; s.ulac = 3'b001; s.iord = 1'b1;
      exp_q.push_back(s);
      s.memw = 1'b1;
      exp_q.push_back(s);
    end else if (op == 6'h04 || op == 6'h05) begin
      s.mulaa = 1'b1; s.ulac = 3'b111;
      exp_q.push_back(s);
      if ((op == 6'h04) == eq) begin
        s = '0; s.cause = model_cause; s.mulab = 2'b11; s.ulac = 3'b001; s.pcw = 1'b1;
        exp_q.push_back(s);
      end
    end else if (op == 6'h02) begin
      s.pcsrc = 2'b10; s.pcw = 1'b1;
      exp_q.push_back(s);
    end else begin
      push_exc(2'b01);
    end
  endtask

  // Runs one instruction cycle by cycle; cut >= 0 stops after that step index.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic eq, input logic of, input int cut);
    ctl_t act;
    build(op, fn, eq, of);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (cut >= 0 && i > cut) break;
      @(negedge clk);
      bus.OPCODE = (i <= W) ? 6'($urandom) : op;
      bus.FUNCT  = (i <= W) ? 6'($urandom) : fn;
      bus.Eq     = (i <= W) ? 1'($urandom) : eq;
      bus.Of     = (i <= W) ? 1'($urandom) : of;
      {bus.Ng, bus.Zr, bus.Gt, bus.Lt} = 4'($urandom);
      #1;
      act = sample();
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s step %0d: got %h want %h", name, i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    ctl_t act;
    reset = 1'b0;
    {bus.Of, bus.Ng, bus.Zr, bus.Eq, bus.Gt, bus.Lt} = '0;
    bus.OPCODE = '0;
    bus.FUNCT  = '0;
    repeat (2) @(posedge clk);
    #1;
    act = sample();
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL reset_held: got %h want 0", act);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    act = sample();
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL reset_released_rst: got %h want 0", act);
    end
  endtask

  task automatic test_alu();
    run_instr("add", 6'h00, 6'h20, 1'b0, 1'b0, -1);
    run_instr("sub", 6'h00, 6'h22, 1'b1, 1'b0, -1);
    run_instr("and", 6'h00, 6'h24, 1'b0, 1'b0, -1);
    run_instr("addi", 6'h08, 6'h11, 1'b0, 1'b0, -1);
  endtask

  task automatic test_mem();
    run_instr("lw", 6'h23, 6'h00, 1'b0, 1'b1, -1);
    run_instr("sw", 6'h2B, 6'h00, 1'b1, 1'b1, -1);
  endtask

  task automatic test_branch_jump();
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0, -1);
    run_instr("beq_not", 6'h04, 6'h00, 1'b0, 1'b0, -1);
    run_instr("bne_taken", 6'h05, 6'h00, 1'b0, 1'b1, -1);
    run_instr("bne_not", 6'h05, 6'h00, 1'b1, 1'b0, -1);
    run_instr("j", 6'h02, 6'h3A, 1'b0, 1'b0, -1);
  endtask

  task automatic test_illegal();
    run_instr("ill_op", 6'h3F, 6'h20, 1'b0, 1'b0, -1);
    run_instr("after_trap", 6'h02, 6'h00, 1'b0, 1'b0, -1);
    run_instr("ill_funct", 6'h00, 6'h21, 1'b0, 1'b0, -1);
  endtask

  task automatic test_overflow();
    run_instr("addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1, -1);
    run_instr("add_ovf", 6'h00, 6'h20, 1'b0, 1'b1, -1);
    run_instr("sub_ovf", 6'h00, 6'h22, 1'b0, 1'b1, -1);
    run_instr("and_ovf", 6'h00, 6'h24, 1'b0, 1'b1, -1);
    run_instr("addi_noovf", 6'h08, 6'h00, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_sw();
    ctl_t act;
    run_instr("sw_cut", 6'h2B, 6'h00, 1'b0, 1'b0, W + 3);
    #1;
    reset = 1'b0;
    #1;
    act = sample();
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_sw: got %h want 0", act);
    end
    model_cause = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    act = sample();
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_sw_rst: got %h want 0", act);
    end
    run_instr("add_after_rst", 6'h00, 6'h20, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [5:0] ops [9];
    logic [5:0] op, fn;
    int         k;
    ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    for (int n = 0; n < 60; n++) begin
      k  = int'($urandom_range(0, 8));
      op = (k == 8) ? 6'($urandom) : ops[k];
      case ($urandom_range(0, 3))
        0:       fn = 6'h20;
        1:       fn = 6'h22;
        2:       fn = 6'h24;
        default: fn = 6'($urandom);
      endcase
      run_instr("random", op, fn, 1'($urandom), 1'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_illegal();
    test_overflow();
    test_reset_mid_sw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
